accel_wrapper: RTL and testbench
================================

// Module: accel_wrapper
// PURPOSE
//  Command-driven 1024-bit accelerator shell between a 32-bit command/status port pair and a 1024-bit BRAM-style data bus.
//  Commands load an operand register from the bus, compute on it, or write it back to the bus.
//  Completion of every command is flagged on port2 for the host/CPU side.
// PARAMETERS
//  WORD_W  32  compute datapath word width; must divide 1024 (1024/WORD_W words per compute pass)
// PORTS
//  clk              in   1     sole clock, rising edge
//  resetn           in   1     asynchronous, active-low reset
//  bram_din         in   1024  operand data from BRAM side
//  bram_din_valid   in   1     bram_din valid strobe
//  bram_dout        out  1024  result data to BRAM side (= operand register R)
//  bram_dout_valid  out  1     bram_dout ready for pickup
//  bram_dout_read   in   1     BRAM side has taken bram_dout
//  port1_din        in   32    command word; [1:0] opcode, [31:2] ignored
//  port1_valid      in   1     command present
//  port1_read       out  1     command accepted (held, see ACK)
//  port2_valid      out  1     command finished
//  port2_read       in   1     host acknowledges completion
//  leds             out  4     {1'b0, state[2:0]}
// BEHAVIOUR
//  Reset: one clock, resetn async active-low; all outputs 0, R=0, state IDLE; reset mid-command aborts to IDLE.
//  Opcodes: 0 CMD_READ, 1 CMD_COMPUTE, 2 CMD_WRITE, 3 reserved (no-op, still completes).
//  FSM states/codes: IDLE=0 ACK=1 READ=2 COMPUTE=3 WRITE=4 DONE=5; all outputs registered.
//  IDLE: port1_valid=1 -> latch port1_din[1:0], go ACK next edge; bram_din_valid in IDLE ignored.
//  ACK: port1_read=1; stay until port1_valid=0, then go READ/COMPUTE/WRITE/DONE by opcode.
//  READ: wait (level) for bram_din_valid=1; that edge R<=bram_din, go DONE.
//  COMPUTE: R <= R + R mod 2^1024 (left shift by 1, MSB lost), word-serial:
//   word index i=0..N-1 (N=1024/WORD_W), LSW first, one word/cycle, carry reg between words, carry-in 0;
//   latency N cycles (32 at default) then DONE; R updated word-by-word in place.
//  WRITE: bram_dout_valid=1 (bram_dout=R, stable); on bram_dout_read=1 clear valid, go DONE.
//  DONE: port2_valid=1; on port2_read=1 clear, go IDLE. port2_read held high into IDLE is ignored.
//  port1_valid while busy is not accepted until FSM back in IDLE.
//  bram_dout always reflects R (also outside WRITE); only bram_dout_valid qualifies it.
// CONFIGURATION
//  FAST_COMPUTE_EN defined: COMPUTE does full 1024-bit R<=R+R in a single cycle (latency 1).
//  Not defined: word-serial compute as above (latency 1024/WORD_W). Results identical either way.
// TESTING
//  Reset: resetn=0 25ns -> all outputs 0, leds=0.
//  READ: cmd 0, then bram_din with 64'h0123456789abcdef at bits [831:768] -> port2_valid, leds=5 until port2_read.
//  COMPUTE on above: cmd 1 -> port2_valid after 32 cycles (+ACK); R bits [831:768]=64'h02468acf13579bde.
//  WRITE: cmd 2 -> bram_dout_valid=1, bram_dout=R; after bram_dout_read -> port2_valid.
//  Carry: load 1024'h...0_FFFFFFFF_8000_0000 pattern (word0=32'h80000000, word1=32'hFFFFFFFF), compute -> word0=0, word1=32'hFFFFFFFF, word2=1.
//  Wrap/reserved: R MSB=1 compute drops it; cmd 3 -> port2_valid without touching R; resetn low mid-COMPUTE -> IDLE, R=0.

Source files
------------

// File: rtl/accel_if.sv
// Host command/status ports and BRAM data bus of the 1024-bit accelerator shell.
interface accel_if;
    logic [1023:0] bram_din;
    logic          bram_din_valid;
    logic [1023:0] bram_dout;
    logic          bram_dout_valid;
    logic          bram_dout_read;
    logic [31:0]   port1_din;
    logic          port1_valid;
    logic          port1_read;
    logic          port2_valid;
    logic          port2_read;
    logic [3:0]    leds;

    modport slave (
        input  bram_din, bram_din_valid, bram_dout_read, port1_din, port1_valid, port2_read,
        output bram_dout, bram_dout_valid, port1_read, port2_valid, leds
    );
    modport master (
        output bram_din, bram_din_valid, bram_dout_read, port1_din, port1_valid, port2_read,
        input  bram_dout, bram_dout_valid, port1_read, port2_valid, leds
    );
endinterface

// File: rtl/accel_wrapper.sv
// Command-driven 1024-bit accelerator shell: load / double / store operand register R.
// FAST_COMPUTE_EN: single-cycle R+R instead of the word-serial datapath.
module accel_wrapper #(
    parameter int WORD_W = 32
) (
    input  logic clk,
    input  logic resetn,
    accel_if.slave bus
);
    localparam int DATA_W = 1024;
    localparam int N      = DATA_W / WORD_W;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACK     = 3'd1,
        S_READ    = 3'd2,
        S_COMPUTE = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  op_q, op_d;
    logic [N-1:0][WORD_W-1:0]    r_q, r_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        carry_q, carry_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            op_q    <= 2'd0;
            r_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        r_d     = r_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE: begin
                if (bus.port1_valid) begin
                    op_d    = bus.port1_din[1:0];
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!bus.port1_valid) begin
                    idx_d   = '0;
                    carry_d = 1'b0;
                    case (op_q)
                        2'd0:    state_d = S_READ;
                        2'd1:    state_d = S_COMPUTE;
                        2'd2:    state_d = S_WRITE;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_READ: begin
                if (bus.bram_din_valid) begin
                    r_d     = bus.bram_din;
                    state_d = S_DONE;
                end
            end
            S_COMPUTE: begin
`ifdef FAST_COMPUTE_EN
                r_d     = r_q << 1;
                state_d = S_DONE;
`else
                // Doubling a word is a 1-bit shift; its MSB is the carry into the next word.
                r_d[idx_q] = {r_q[idx_q][WORD_W-2:0], carry_q};
                carry_d    = r_q[idx_q][WORD_W-1];
                idx_d      = idx_q + 1'b1;
                if (idx_q == IDX_W'(N - 1))
                    state_d = S_DONE;
`endif
            end
            S_WRITE: begin
                if (bus.bram_dout_read)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.port2_read)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every handshake output is a pure decode of the state register, so all are registered.
    assign bus.bram_dout       = r_q;
    assign bus.bram_dout_valid = (state_q == S_WRITE);
    assign bus.port1_read      = (state_q == S_ACK);
    assign bus.port2_valid     = (state_q == S_DONE);
    assign bus.leds            = {1'b0, state_q};

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^bus.port1_din[31:2];
endmodule

// File: tb/tb_accel_wrapper.sv
// Table-driven bench for accel_wrapper with a scoreboard of expected R values.
module tb_accel_wrapper;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    accel_if bus ();
    accel_wrapper #(.WORD_W(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

`ifdef FAST_COMPUTE_EN
    localparam int CLAT = 1;
`else
    localparam int CLAT = 32;
`endif

    typedef struct {
        logic [1:0]    op;
        logic [1023:0] din;
        logic [1023:0] exp;
    } vec_t;

    vec_t          tv[9];
    logic [1023:0] sb_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            for (int k = 0; k < 16; k++)
                if (act[k*64 +: 64] !== exp[k*64 +: 64]) begin
                    $display("FAIL %s: chunk %0d got %h expected %h", nm, k, act[k*64 +: 64], exp[k*64 +: 64]);
                    break;
                end
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [1023:0] din, input logic [1023:0] exp);
        int  ccnt = 0;
        bit  wseen = 0;
        logic [1023:0] e;
        sb_q.push_back(exp);
        bus.port1_din   = {30'h15555555, op};
        bus.port1_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.port1_read) break;
        end
        chk("ack", 64'(bus.port1_read), 64'd1);
        bus.port1_valid = 1'b0;
        if (op == 2'd0) begin
            bus.bram_din       = din;
            bus.bram_din_valid = 1'b1;
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.leds == 4'd3) ccnt++;
            if (bus.leds != 4'd1 && bus.leds != 4'd2) bus.bram_din_valid = 1'b0;
            if (bus.bram_dout_valid && !wseen) begin
                wseen = 1;
                chk_wide("write_data", bus.bram_dout, exp);
            end
            bus.bram_dout_read = bus.bram_dout_valid;
            if (bus.port2_valid) break;
        end
        bus.bram_dout_read = 1'b0;
        bus.bram_din_valid = 1'b0;
        chk("done_valid", 64'(bus.port2_valid), 64'd1);
        chk("done_leds", 64'(bus.leds), 64'd5);
        e = sb_q.pop_front();
        chk_wide("result_r", bus.bram_dout, e);
        if (op == 2'd1) chk("compute_latency", 64'(ccnt), 64'(CLAT));
        if (op == 2'd2) chk("write_seen", 64'(wseen), 64'd1);
        @(negedge clk);
        chk("done_held", 64'(bus.port2_valid), 64'd1);
        bus.port2_read = 1'b1;
        @(negedge clk);
        chk("back_idle", 64'(bus.leds), 64'd0);
        @(negedge clk);
        chk("p2read_held_ignored", 64'({bus.leds, bus.port1_read}), 64'd0);
        bus.port2_read = 1'b0;
    endtask

    initial begin
        logic [1023:0] a, b, c, cx, d;
        a  = 1024'h0123456789abcdef;  a = a << 768;
        b  = 1024'h02468acf13579bde;  b = b << 768;
        c  = 1024'hFFFFFFFF_80000000;
        cx = 1024'h1_FFFFFFFF_00000000;
        d  = 1024'h5;  d[1023] = 1'b1;
        tv[0] = '{2'd0, a,   a};
        tv[1] = '{2'd1, '0,  b};
        tv[2] = '{2'd2, '0,  b};
        tv[3] = '{2'd0, c,   c};
        tv[4] = '{2'd1, '0,  cx};
        tv[5] = '{2'd0, d,   d};
        tv[6] = '{2'd1, '0,  1024'd10};
        tv[7] = '{2'd3, '0,  1024'd10};
        tv[8] = '{2'd2, '0,  1024'd10};

        resetn             = 1'b0;
        bus.bram_din       = '0;
        bus.bram_din_valid = 1'b0;
        bus.bram_dout_read = 1'b0;
        bus.port1_din      = '0;
        bus.port1_valid    = 1'b0;
        bus.port2_read     = 1'b0;
        #25;
        chk("rst_flags", 64'({bus.port1_read, bus.port2_valid, bus.bram_dout_valid}), 64'd0);
        chk("rst_leds", 64'(bus.leds), 64'd0);
        chk_wide("rst_r", bus.bram_dout, '0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_cmd(tv[i].op, tv[i].din, tv[i].exp);

        // Data strobed while idle must not load R.
        bus.bram_din       = {16{64'hdeadbeefcafef00d}};
        bus.bram_din_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.bram_din_valid = 1'b0;
        chk_wide("idle_din_ignored", bus.bram_dout, 1024'd10);
        chk("idle_stays", 64'(bus.leds), 64'd0);

        // Reset in the middle of a compute aborts and clears R.
        bus.port1_din   = 32'd1;
        bus.port1_valid = 1'b1;
        @(negedge clk);
        bus.port1_valid = 1'b0;
        @(negedge clk);
        chk("mid_compute_state", 64'(bus.leds), 64'd3);
        resetn = 1'b0;
        #1;
        chk("abort_leds", 64'(bus.leds), 64'd0);
        chk_wide("abort_r", bus.bram_dout, '0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_cmd(2'd0, a, a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
